// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches to a 1-cycle imem
// and buffers returned words with their PCs for the decode stage.
module inst_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INST_W-1:0]        out_inst,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pcn,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     misalign_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [OW:0] DEPTH_C = (OW + 1)'(DEPTH);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              infl_q, infl_d;
  logic              kill_q, kill_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic              mis_q, mis_d;

  logic [OW:0]       fill;
  logic              push;
  logic              pop;

  // Credit check counts the word already in flight so a full queue
  // can never be overrun by a late response.
  always_comb begin
    fill    = {1'b0, occ_q} + (OW + 1)'(infl_q);
    imem_en = reset && !redirect_valid && (fill < DEPTH_C);
    push    = infl_q && !kill_q && !redirect_valid;
    pop     = out_valid && out_ready;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    infl_d     = imem_en;
    kill_d     = 1'b0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    mis_d      = mis_q;
    if (imem_en) begin
      infl_pc_d = fetch_pc_q;
    end
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
      kill_d     = 1'b1;
      wptr_d     = '0;
      rptr_d     = '0;
      occ_d      = '0;
      if (redirect_pc[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
    end else begin
      if (imem_en) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      occ_d  = occ_q + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      infl_q     <= 1'b0;
      kill_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      mis_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      infl_q     <= infl_d;
      kill_q     <= kill_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      mis_q      <= mis_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wptr_q] <= imem_data;
      pc_mem[wptr_q]   <= infl_pc_q;
    end
  end

  always_comb begin
    imem_addr    = fetch_pc_q;
    occupancy    = occ_q;
    misalign_err = mis_q;
    out_valid    = (occ_q != '0);
    out_inst     = '0;
    out_pc       = '0;
    out_pcn      = '0;
    if (out_valid) begin
      out_inst = inst_mem[rptr_q];
      out_pc   = pc_mem[rptr_q];
      out_pcn  = pc_mem[rptr_q] + ADDR_W'(4);
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: imem returns addr>>2, a scoreboard of
// expected PCs is refilled on every reset or redirect.
module tb_inst_fetch_queue;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b1;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pcn;
  logic [2:0]  occupancy;
  logic        misalign_err;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  inst_fetch_queue dut (
    .clock(clock),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .out_pc(out_pc),
    .out_pcn(out_pcn),
    .occupancy(occupancy),
    .misalign_err(misalign_err)
  );

  always #5 clock = ~clock;

  // Memory model: valid word one cycle after a strobe, junk otherwise.
  logic        was_en = 1'b0;
  logic [31:0] resp = '0;
  logic [31:0] junk = '0;
  always @(posedge clock) begin
    was_en <= imem_en;
    resp   <= imem_addr >> 2;
    junk   <= $urandom;
  end
  assign imem_data = was_en ? resp : junk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic refill(input logic [31:0] s);
    exp_q.delete();
    for (int i = 0; i < 600; i++) exp_q.push_back(s + 32'(4 * i));
  endtask

  // Monitor: every accepted head must be the next PC of the stream.
  always @(negedge clock) begin
    if (reset) begin
      chk("occ_le_depth", 32'(occupancy <= 3'd4), 32'd1);
      chk("valid_vs_occ", 32'(out_valid), 32'(occupancy != 3'd0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_inst", out_inst, e >> 2);
          chk("out_pcn", out_pcn, e + 32'd4);
        end
      end
    end
  end

  task automatic do_redirect(input logic [31:0] t);
    redirect_pc = t;
    redirect_valid = 1'b1;
    @(negedge clock);
    #1 refill({t[31:2], 2'b00});
    @(posedge clock);
    #1 redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int want);
    int edges;
    edges = 0;
    while (!out_valid && edges < 10) begin
      @(posedge clock);
      #1 edges++;
    end
    chk(nm, 32'(edges), 32'(want));
  endtask

  task automatic wait_occ3(input string nm);
    int n;
    n = 0;
    while (occupancy != 3'd3 && n < 20) begin
      @(posedge clock);
      #1 n++;
    end
    chk(nm, 32'(occupancy), 32'd3);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_occ"}, 32'(occupancy), 32'd0);
    chk({nm, "_en"}, 32'(imem_en), 32'd0);
    chk({nm, "_mis"}, 32'(misalign_err), 32'd0);
    chk({nm, "_pc"}, out_pc, 32'd0);
    chk({nm, "_pcn"}, out_pcn, 32'd0);
    chk({nm, "_inst"}, out_inst, 32'd0);
    chk({nm, "_addr"}, imem_addr, RPC);
  endtask

  initial begin
    #12 chk_reset_state("reset");
    refill(RPC);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("rel_en", 32'(imem_en), 32'd1);
    chk("rel_addr", imem_addr, RPC);

    // Stream from RESET_PC, one word per cycle from cycle 2.
    @(posedge clock);
    #1 chk("rel_lat1", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1 chk("rel_lat2", 32'(out_valid), 32'd1);
    chk("rel_first_pc", out_pc, RPC);
    for (int i = 0; i < 16; i++) begin
      @(posedge clock);
      #1 chk("rate", 32'(out_valid), 32'd1);
    end

    // Stall: queue saturates, fetch stops.
    out_ready = 1'b0;
    repeat (10) @(posedge clock);
    #1 chk("stall_occ", 32'(occupancy), 32'd4);
    chk("stall_en", 32'(imem_en), 32'd0);
    out_ready = 1'b1;
    repeat (20) @(posedge clock);
    #1;

    // Redirect with 3 queued and one in flight; head popped same cycle.
    out_ready = 1'b0;
    wait_occ3("pre_redir_occ");
    chk("pre_redir_en", 32'(imem_en), 32'd0);
    out_ready = 1'b1;
    do_redirect(32'h0040_0100);
    chk("redir_occ", 32'(occupancy), 32'd0);
    wait_valid("redir_lat", 2);
    chk("redir_pc", out_pc, 32'h0040_0100);
    repeat (5) @(posedge clock);
    #1;

    // Misaligned target.
    do_redirect(32'h0040_0102);
    chk("mis_set", 32'(misalign_err), 32'd1);
    wait_valid("mis_lat", 2);
    chk("mis_pc", out_pc, 32'h0040_0100);
    repeat (5) @(posedge clock);
    #1 do_redirect(32'h0040_0200);
    chk("mis_sticky", 32'(misalign_err), 32'd1);
    wait_valid("al_lat", 2);

    // Address wrap.
    do_redirect(32'hFFFF_FFFC);
    wait_valid("wrap_lat", 2);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    chk("wrap_pcn0", out_pcn, 32'h0000_0000);
    @(posedge clock);
    #1 chk("wrap_pc1", out_pc, 32'h0000_0000);
    chk("wrap_pcn1", out_pcn, 32'h0000_0004);

    // Random consumer and redirects.
    repeat (300) begin
      @(posedge clock);
      #1 out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) do_redirect($urandom);
    end
    chk("mis_before_reset", 32'(misalign_err), 32'd1);

    // Asynchronous reset mid-burst.
    @(posedge clock);
    #1 out_ready = 1'b0;
    wait_occ3("pre_rst_occ");
    @(negedge clock);
    #2 reset = 1'b0;
    #1 chk_reset_state("async");
    refill(RPC);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1 chk("rst_no_push", 32'(occupancy), 32'd0);
    end
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("rst2_en", 32'(imem_en), 32'd1);
    chk("rst2_addr", imem_addr, RPC);
    wait_valid("rst2_lat", 2);
    chk("rst2_pc", out_pc, RPC);
    repeat (20) @(posedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the PC and instruction-address width.
REQ-002 SHALL have parameter INST_W, default 32, the instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, the queue entries; power of 2, minimum 2.
REQ-004 SHALL have parameter RESET_PC, default 32'h0040_0000, the first fetch address.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clock, input, 1, the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port redirect_valid, input, 1, taken branch, jump or jr this cycle.
REQ-009 SHALL have port redirect_pc, input, ADDR_W, the redirect target.
REQ-010 SHALL have port imem_en, output, 1, the instruction memory read strobe.
REQ-011 SHALL have port imem_addr, output, ADDR_W, the instruction memory address.
REQ-012 SHALL have port imem_data, input, INST_W, the read data, valid exactly 1 cycle after imem_en.
REQ-013 SHALL have port out_valid, output, 1, meaning a queue head is present.
REQ-014 SHALL have port out_ready, input, 1, the consumer accept.
REQ-015 SHALL have ports out_inst (INST_W), out_pc (ADDR_W) and out_pcn (ADDR_W), all outputs: head instruction, its address, and address+4.
REQ-016 SHALL have port occupancy, output, clog2(DEPTH)+1, the valid entries.
REQ-017 SHALL have port misalign_err, output, 1, a sticky misaligned-redirect flag.

Function
REQ-018 SHALL assert imem_en combinationally when occupancy + inflight < DEPTH and redirect_valid=0, where inflight is 1 if imem_en was high the previous cycle.
REQ-019 SHALL drive imem_addr = fetch_pc always; fetch_pc SHALL advance by 4 on each issue, wrapping modulo 2^ADDR_W.
REQ-020 SHALL push imem_data with its address, tracked in an inflight-PC register, into the queue at the edge ending the cycle after issue, unless killed.
REQ-021 SHALL make out_valid = (occupancy != 0); out_inst, out_pc and out_pcn SHALL reflect the head entry; a pop SHALL occur when out_valid and out_ready.
REQ-022 SHALL, on simultaneous push and pop, leave occupancy unchanged; read and write pointers SHALL wrap at DEPTH.
REQ-023 SHALL never overflow a full queue, guaranteed by REQ-018; a pop with the queue empty SHALL have no effect.
REQ-024 SHALL, on redirect_valid at a rising edge: clear the queue (occupancy becomes 0), set fetch_pc to {redirect_pc[ADDR_W-1:2], 2'b00}, and mark any inflight response killed so it is discarded next cycle.
REQ-025 SHALL accept a pop in a redirect cycle (the consumer has taken the head), with the queue still ending empty.
REQ-026 SHALL set misalign_err on redirect_pc[1:0] != 0; it SHALL clear only on reset.
REQ-027 SHALL have redirect-to-out_valid latency of exactly 2 cycles: issue in cycle N+1, data in N+2, out_valid in N+2 after the push edge.
REQ-028 SHALL sustain 1 instruction per cycle when out_ready is held high.
REQ-029 SHALL compute out_pcn = out_pc + 4, modulo 2^ADDR_W.

Reset
REQ-030 SHALL, while reset=0 and regardless of clock: set fetch_pc = RESET_PC, set occupancy = 0, clear the pointers, inflight and kill, and drive out_valid=0, imem_en=0, misalign_err=0, and out_inst, out_pc and out_pcn to 0.
REQ-031 SHALL, on reset deassertion, assert imem_en with imem_addr = RESET_PC in the first cycle.
REQ-032 SHALL, on reset asserted mid-operation, discard queue contents and inflight data immediately; no push SHALL occur until reset deasserts.

Verification
REQ-033 The bench SHALL cover: reset release with out_ready=1 and imem returning addr>>2 -> out_pc = 0x00400000, 0x00400004, ... on consecutive cycles from cycle 2, and out_pcn = out_pc+4.
REQ-034 The bench SHALL cover: out_ready=0 for 10 cycles -> occupancy saturates at DEPTH=4, imem_en low once occupancy+inflight = 4, and no entry is lost or duplicated after release.
REQ-035 The bench SHALL cover: redirect_valid with redirect_pc = 0x00400100 while 3 entries are queued and a read is inflight -> occupancy 0 next cycle, the inflight word is dropped, and the next out_pc = 0x00400100 exactly 2 cycles later.
REQ-036 The bench SHALL cover: redirect_pc = 0x00400102 -> misalign_err=1 and the fetch resumes at 0x00400100; misalign_err stays 1 until reset.
REQ-037 The bench SHALL cover: ADDR_W=32 with redirect_pc = 0xFFFFFFFC -> the following out_pc = 0x00000000 and out_pcn = 0x00000004.
REQ-038 The bench SHALL cover: reset=0 asserted asynchronously mid-burst with occupancy 3 -> out_valid=0 and occupancy=0 before the next edge, and the restart is at RESET_PC.
